uart_rx_frame: RTL and testbench
================================

Name: uart_rx_frame

Overview:
UART receive deframer. It sits directly downstream of the baud rate generator and consumes its 16x-oversample rate as a one-cycle enable strobe (rxTick) in the clk domain. It synchronises the serial line, validates the start bit at mid-bit, and majority-votes each data and stop bit. Received bytes go out over a valid/ready handshake, with frame-error and overrun reporting.

Parameters:
DATA_BITS, 8, data bits per frame; LSB first; no parity.
OVERSAMPLE, 16, rxTick strobes per bit period; must be even and >= 8.

Ports:
clk  input  1  board clock; all logic is on the rising edge.
rstN  input  1  reset, asynchronous, active-low.
rxTick  input  1  oversample strobe; one clk cycle wide per pulse; may be tied high.
rx  input  1  asynchronous serial line; idles high.
outData  output  DATA_BITS  received word; stable while outValid=1.
outValid  output  1  word available; held until accepted.
outReady  input  1  consumer accepts the word when outValid&&outReady.
frameError  output  1  one-cycle pulse: stop bit sampled low.
overrun  output  1  one-cycle pulse: a frame completed while the previous word was unaccepted.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync deassert):
  - state=IDLE; synchroniser flops=1; counters=0; outData=0.
  - outValid, frameError, overrun and busy are all 0.
  - Reset mid-frame abandons the frame; no pulse is issued.
- rx passes through a 2-flop synchroniser (reset value 1) to give rxS. All logic uses rxS only. Latency rx->rxS is 2 clk.
- The FSM advances only on cycles with rxTick=1. The output handshake works on every clk.
- IDLE:
  - On a tick with rxS=0: go to START, tickCnt=0.
- START:
  - Each tick: if tickCnt==OVERSAMPLE/2-1, check rxS.
    - rxS=1: glitch; go to IDLE.
    - rxS=0: go to DATA with tickCnt=0, bitCnt=0.
  - Otherwise tickCnt++.
- Voting (DATA, STOP, BREAK):
  - Each tick shifts rxS into 2-bit history hist.
  - Decision tick is tickCnt==OVERSAMPLE-1. The bit is majority(hist[1], hist[0], rxS), i.e. the last 3 ticks.
  - On the decision tick tickCnt wraps to 0; otherwise tickCnt++.
- DATA:
  - On each decision tick: shiftReg <= {bit, shiftReg[DATA_BITS-1:1]}; bitCnt++.
  - After DATA_BITS decisions go to STOP.
- STOP, on decision tick:
  - bit=1: deliver shiftReg; go to IDLE.
  - bit=0: pulse frameError; drop the word; go to BREAK.
- BREAK:
  - Go to IDLE on the first tick with rxS=1. A held-low line therefore produces exactly one frameError.
- Deliver, evaluated in the cycle after the STOP decision tick:
  - If !outValid or outReady: outData<=word, outValid<=1.
  - Else: pulse overrun; keep the old outData and outValid=1; the new word is lost.
- Handshake:
  - outValid&&outReady with no simultaneous deliver: outValid<=0 next cycle.
  - Simultaneous accept and deliver: outValid stays 1 and outData is updated.
- busy=(state!=IDLE) as a registered decode.
- Counter widths: tickCnt is $clog2(OVERSAMPLE) bits; bitCnt is $clog2(DATA_BITS+1) bits. Wrap is explicit; no overflow is relied on.

Decomposition:
- Shared package uart_pkg holds:
  - state enum {IDLE, START, DATA, STOP, BREAK};
  - default DATA_BITS/OVERSAMPLE localparams;
  - majority3 function.
- One sub-module, uart_sync2: 2-flop synchroniser with parameterised reset value (1 here), reusable for other async inputs.

Test Plan:
- rxTick=1 every cycle, line sends 0x5A at 16 clk/bit with stop=1 -> outData=0x5A, outValid=1 within 3 clk of stop mid-bit; frameError=0; busy=1 through the frame, then 0.
- rx low pulse of 5 ticks from idle -> return to IDLE after the 8th tick; no outValid; busy=1 then 0.
- Frame 0xFF with stop bit 0, then line held low 40 bit-times -> one frameError pulse, no outValid; busy stays high until rx returns high.
- Single-tick glitch (1 of 16 ticks inverted) mid-bit on every bit of 0x33 -> outData=0x33 (majority vote absorbs it).
- outReady=0; frames 0x11 then 0x22 -> outData stays 0x11, overrun pulses once; then outReady=1 -> outValid drops the next cycle.
- outReady asserted in the same cycle 0x44 is delivered while 0x11 is pending -> outValid stays 1, outData=0x44, no overrun.
- rstN pulsed low mid-DATA -> all outputs 0 immediately; the next clean frame 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// Holds the deframer state encoding, default frame geometry and the 2-of-3 vote.
package uart_pkg;

  localparam int DATA_BITS_DEF  = 8;
  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// RESET_VAL lets the flops reset to the input's idle level.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstN,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive deframer: mid-bit start validation, 3-sample majority vote per bit,
// valid/ready output with frame-error and overrun pulses.
//
// Handshake: outData is offered while outValid=1 and is consumed on any clk edge
// where outValid && outReady; outValid stays high until then.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 rxTick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] outData,
  output logic                 outValid,
  input  logic                 outReady,
  output logic                 frameError,
  output logic                 overrun,
  output logic                 busy,
  output logic [2:0]           dbg_state
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  state_t                state;
  state_t                state_nxt;
  logic                  rx_s;
  logic [TICK_W-1:0]     tick_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [1:0]            hist;
  logic [DATA_BITS-1:0]  shift_reg;
  logic                  deliver_pend;

  logic                  vote;
  logic                  half_hit;
  logic                  full_hit;
  logic                  voting;
  logic                  shift_en;
  logic                  word_done;
  logic                  frame_bad;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rstN (rstN),
    .d    (rx),
    .q    (rx_s)
  );

  // State register
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  // Next-state logic; the FSM only moves on oversample ticks
  always_comb begin
    state_nxt = state;
    if (rxTick) begin
      case (state)
        IDLE:    if (!rx_s) state_nxt = START;
        START:   if (half_hit) state_nxt = rx_s ? IDLE : DATA;
        DATA:    if (full_hit && bit_cnt == BIT_LAST) state_nxt = STOP;
        STOP:    if (full_hit) state_nxt = vote ? IDLE : BREAK;
        BREAK:   if (rx_s) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output / control decode
  always_comb begin
    vote      = majority3(hist[1], hist[0], rx_s);
    half_hit  = (tick_cnt == HALF_LAST);
    full_hit  = (tick_cnt == FULL_LAST);
    voting    = (state == DATA) || (state == STOP) || (state == BREAK);
    shift_en  = rxTick && (state == DATA) && full_hit;
    word_done = rxTick && (state == STOP) && full_hit && vote;
    frame_bad = rxTick && (state == STOP) && full_hit && !vote;
    dbg_state = state;
  end

  // Bit timing counters, vote history and shift register
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      hist      <= 2'b11;
      shift_reg <= '0;
    end else if (rxTick) begin
      case (state)
        IDLE:    tick_cnt <= '0;
        START:   tick_cnt <= half_hit ? '0 : tick_cnt + 1'b1;
        default: tick_cnt <= full_hit ? '0 : tick_cnt + 1'b1;
      endcase
      if (state == IDLE || state == START) bit_cnt <= '0;
      else if (shift_en)                   bit_cnt <= bit_cnt + 1'b1;
      if (voting) hist <= {hist[0], rx_s};
      if (shift_en) shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
    end
  end

  // Delivery happens the cycle after the stop decision; shift_reg is stable until the next DATA state.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      deliver_pend <= 1'b0;
      frameError   <= 1'b0;
      overrun      <= 1'b0;
      outData      <= '0;
      outValid     <= 1'b0;
    end else begin
      deliver_pend <= word_done;
      frameError   <= frame_bad;
      overrun      <= deliver_pend && outValid && !outReady;
      if (deliver_pend && (!outValid || outReady)) begin
        outData  <= shift_reg;
        outValid <= 1'b1;
      end else if (outValid && outReady) begin
        outValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: 16 clk per bit (rxTick tied high),
// hand-computed expectations checked with immediate assertions.
module tb_uart_rx_frame;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       rxTick = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] outData;
  logic       outValid;
  logic       outReady = 1'b0;
  logic       frameError;
  logic       overrun;
  logic       busy;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int busy_cnt = 0;
  int fe0, ov0, b0;

  uart_rx_frame #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk        (clk),
    .rstN       (rstN),
    .rxTick     (rxTick),
    .rx         (rx),
    .outData    (outData),
    .outValid   (outValid),
    .outReady   (outReady),
    .frameError (frameError),
    .overrun    (overrun),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Pulse and busy monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (frameError) fe_cnt++;
    if (overrun)    ov_cnt++;
    if (busy)       busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold rx at v for n clk cycles; inputs change 1 time unit after the edge
  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      rx = v;
      @(posedge clk);
      #1;
    end
  endtask

  // One frame of 16 clk per bit: start, 8 data bits LSB first, stop.
  // glitch inverts offset 7 of every data bit; outReady pulses high in cycle ready_at.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input bit glitch,
                            input int ready_at, input int ncyc);
    int  b;
    int  off;
    logic v;
    for (int i = 0; i < ncyc; i++) begin
      b   = i / 16;
      off = i % 16;
      if (b == 0)      v = 1'b0;
      else if (b <= 8) v = d[b-1];
      else             v = stop_bit;
      if (glitch && b >= 1 && b <= 8 && off == 7) v = ~v;
      rx       = v;
      outReady = (i == ready_at);
      @(posedge clk);
      #1;
    end
    outReady = 1'b0;
  endtask

  task automatic accept();
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_outValid", outValid, 0);
    check("rst_outData", outData, 0);
    check("rst_busy", busy, 0);
    check("rst_frameError", frameError, 0);
    check("rst_overrun", overrun, 0);
    check("rst_state", dbg_state, 0);
    rstN = 1'b1;
    drive(1'b1, 10);

    // Clean frame 0x5A
    fe0 = fe_cnt;
    b0  = busy_cnt;
    send_frame(8'h5A, 1'b1, 1'b0, -1, 160);
    check("f5a_outValid", outValid, 1);
    check("f5a_outData", outData, 8'h5A);
    check("f5a_frameError", fe_cnt - fe0, 0);
    check("f5a_busy_cycles", busy_cnt - b0, 152);
    check("f5a_busy_end", busy, 0);
    accept();
    check("f5a_accept", outValid, 0);
    drive(1'b1, 10);

    // Short low pulse rejected at the start-bit midpoint
    b0 = busy_cnt;
    drive(1'b0, 5);
    drive(1'b1, 30);
    check("glitch_busy_cycles", busy_cnt - b0, 8);
    check("glitch_outValid", outValid, 0);
    check("glitch_busy_end", busy, 0);

    // 0xFF with low stop bit, line then held low: exactly one frameError
    fe0 = fe_cnt;
    send_frame(8'hFF, 1'b0, 1'b0, -1, 160);
    drive(1'b0, 640);
    check("brk_frameError", fe_cnt - fe0, 1);
    check("brk_busy_held", busy, 1);
    check("brk_outValid", outValid, 0);
    drive(1'b1, 10);
    check("brk_busy_end", busy, 0);
    check("brk_frameError_end", fe_cnt - fe0, 1);
    check("brk_outValid_end", outValid, 0);

    // One inverted tick per data bit is voted out
    send_frame(8'h33, 1'b1, 1'b1, -1, 160);
    check("vote_outValid", outValid, 1);
    check("vote_outData", outData, 8'h33);
    accept();
    drive(1'b1, 10);

    // Overrun: 0x22 arrives while 0x11 is pending
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1, 1'b0, -1, 160);
    drive(1'b1, 10);
    send_frame(8'h22, 1'b1, 1'b0, -1, 160);
    check("ovr_outData", outData, 8'h11);
    check("ovr_outValid", outValid, 1);
    check("ovr_count", ov_cnt - ov0, 1);
    accept();
    check("ovr_drop", outValid, 0);
    drive(1'b1, 10);

    // Accept of 0x11 coincides with delivery of 0x44
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1, 1'b0, -1, 160);
    drive(1'b1, 10);
    send_frame(8'h44, 1'b1, 1'b0, 155, 160);
    check("same_outValid", outValid, 1);
    check("same_outData", outData, 8'h44);
    check("same_overrun", ov_cnt - ov0, 0);

    // Reset mid-DATA, then a clean frame
    fe0 = fe_cnt;
    send_frame(8'hA5, 1'b1, 1'b0, -1, 64);
    rstN = 1'b0;
    rx   = 1'b1;
    #1;
    check("mid_rst_outValid", outValid, 0);
    check("mid_rst_outData", outData, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_state", dbg_state, 0);
    drive(1'b1, 3);
    rstN = 1'b1;
    drive(1'b1, 10);
    send_frame(8'hC3, 1'b1, 1'b0, -1, 160);
    check("c3_outValid", outValid, 1);
    check("c3_outData", outData, 8'hC3);
    check("c3_frameError", fe_cnt - fe0, 0);
    check("c3_busy_end", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
